// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with a stored {C,Z,N,V} flag register.
//
// One operation is accepted per valid/ready transfer. Single-cycle ops load the
// registered result one edge after the transfer. With ALU_MUL_EN defined, opcode B
// runs an unsigned shift-add multiply taking WIDTH iterations plus a load cycle.
//
// Configuration macro: ALU_MUL_EN (undefined = no multiplier, opcode B illegal).
//
// Ports:
//   i_clk         rising-edge clock
//   i_rst_n       synchronous reset, active low
//   i_in_valid    operation request valid
//   o_in_ready    block can accept an operation
//   i_opcode      operation select
//   i_in_a        operand A
//   i_in_b        operand B (shift amount in i_in_b[SHW-1:0])
//   o_out_valid   result valid
//   i_out_ready   consumer accepts result
//   o_result      result (MUL: low half)
//   o_result_hi   MUL high half, 0 for all other ops
//   o_flags       {C,Z,N,V}
//   o_err         illegal opcode for the held result
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_opcode,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic [3:0]       o_flags,
    output logic             o_err
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_SAR = 4'hA;

`ifdef ALU_MUL_EN
    localparam logic [3:0]   OP_MUL   = 4'hB;
    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH);

    typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StDone = 2'd2} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StDone = 2'd2} state_e;
`endif

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [3:0]       r_flags, w_flags_nxt;
    logic             r_err, w_err_nxt;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   r_result_hi, w_result_hi_nxt;
    logic [2*WIDTH-1:0] r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [SHW:0]       r_cnt, w_cnt_nxt;
`endif

    logic             w_xfer;
    logic             w_c_in;
    logic             w_cin_add;
    logic             w_cin_sub;
    logic [SHW-1:0]   w_sh_amt;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH:0]   w_sar;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic             w_alu_err;
    logic [3:0]       w_alu_flags;

    assign o_in_ready  = (r_state == StIdle) | ((r_state == StDone) & i_out_ready);
    assign o_out_valid = (r_state == StDone);
    assign w_xfer      = i_in_valid & o_in_ready;
    assign o_result    = r_result;
    assign o_flags     = r_flags;
    assign o_err       = r_err;
`ifdef ALU_MUL_EN
    assign o_result_hi = r_result_hi;
`else
    assign o_result_hi = '0;
`endif

    // Single-cycle datapath, all at WIDTH+1 bits so bit WIDTH is the carry.
    // Subtraction is a + ~b + cin, so carry out of 1 means "no borrow".
    assign w_c_in    = r_flags[3];
    assign w_cin_add = (i_opcode == OP_ADC) & w_c_in;
    assign w_cin_sub = (i_opcode == OP_SBC) ? w_c_in : 1'b1;
    assign w_sh_amt  = i_in_b[SHW-1:0];

    assign w_add = {1'b0, i_in_a} + {1'b0, i_in_b} + {{WIDTH{1'b0}}, w_cin_add};
    assign w_sub = {1'b0, i_in_a} + {1'b0, ~i_in_b} + {{WIDTH{1'b0}}, w_cin_sub};
    // Extra bit beside the operand catches the last bit shifted out.
    assign w_shl = {1'b0, i_in_a} << w_sh_amt;
    assign w_shr = {i_in_a, 1'b0} >> w_sh_amt;
    assign w_sar = $unsigned($signed({i_in_a, 1'b0}) >>> w_sh_amt);

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = w_c_in;
        w_alu_v   = 1'b0;
        w_alu_err = 1'b0;
        case (i_opcode)
            OP_ADD, OP_ADC: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
                w_alu_v   = (i_in_a[WIDTH-1] == i_in_b[WIDTH-1]) &
                            (w_add[WIDTH-1] != i_in_a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                w_alu_res = w_sub[WIDTH-1:0];
                w_alu_c   = w_sub[WIDTH];
                w_alu_v   = (i_in_a[WIDTH-1] != i_in_b[WIDTH-1]) &
                            (w_sub[WIDTH-1] != i_in_a[WIDTH-1]);
            end
            OP_AND: w_alu_res = i_in_a & i_in_b;
            OP_OR:  w_alu_res = i_in_a | i_in_b;
            OP_XOR: w_alu_res = i_in_a ^ i_in_b;
            OP_NOT: w_alu_res = ~i_in_a;
            OP_SHL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                if (w_sh_amt != '0) w_alu_c = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_res = w_shr[WIDTH:1];
                if (w_sh_amt != '0) w_alu_c = w_shr[0];
            end
            OP_SAR: begin
                w_alu_res = w_sar[WIDTH:1];
                if (w_sh_amt != '0) w_alu_c = w_sar[0];
            end
            default: w_alu_err = 1'b1;
        endcase
    end

    // Illegal opcodes leave the flag register untouched.
    assign w_alu_flags = w_alu_err ? r_flags
                                   : {w_alu_c, (w_alu_res == '0), w_alu_res[WIDTH-1], w_alu_v};

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;
        w_err_nxt    = r_err;
`ifdef ALU_MUL_EN
        w_result_hi_nxt = r_result_hi;
        w_mcand_nxt     = r_mcand;
        w_mplier_nxt    = r_mplier;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
`endif

        case (r_state)
            StDone: begin
                if (i_out_ready) w_state_nxt = StIdle;
            end
`ifdef ALU_MUL_EN
            StBusy: begin
                if (r_cnt == CNT_LAST) begin
                    // All WIDTH partial products accumulated; load the result.
                    w_state_nxt     = StDone;
                    w_result_nxt    = r_acc[WIDTH-1:0];
                    w_result_hi_nxt = r_acc[2*WIDTH-1:WIDTH];
                    w_err_nxt       = 1'b0;
                    w_flags_nxt     = {(r_acc[2*WIDTH-1:WIDTH] != '0),
                                       (r_acc[WIDTH-1:0] == '0),
                                       r_acc[WIDTH-1],
                                       (r_acc[2*WIDTH-1:WIDTH] != '0)};
                end else begin
                    if (r_mplier[0]) w_acc_nxt = r_acc + r_mcand;
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_cnt_nxt    = r_cnt + 1'b1;
                end
            end
`endif
            default: ;
        endcase

        if (w_xfer) begin
`ifdef ALU_MUL_EN
            if (i_opcode == OP_MUL) begin
                w_state_nxt  = StBusy;
                w_mcand_nxt  = {{WIDTH{1'b0}}, i_in_a};
                w_mplier_nxt = i_in_b;
                w_acc_nxt    = '0;
                w_cnt_nxt    = '0;
            end else
`endif
            begin
                w_state_nxt  = StDone;
                w_result_nxt = w_alu_res;
                w_flags_nxt  = w_alu_flags;
                w_err_nxt    = w_alu_err;
`ifdef ALU_MUL_EN
                w_result_hi_nxt = '0;
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
`ifdef ALU_MUL_EN
            r_result_hi <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_flags  <= w_flags_nxt;
            r_err    <= w_err_nxt;
`ifdef ALU_MUL_EN
            r_result_hi <= w_result_hi_nxt;
            r_mcand     <= w_mcand_nxt;
            r_mplier    <= w_mplier_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=16) against an
// arithmetic reference model. Honours ALU_MUL_EN the same way the design does.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'h0;
    logic [15:0] in_a = 16'h0;
    logic [15:0] in_b = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic [3:0]  flags;
    logic        err;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH(16),
        .SHW  (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_opcode   (opcode),
        .i_in_a     (in_a),
        .i_in_b     (in_b),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_result   (result),
        .o_result_hi(result_hi),
        .o_flags    (flags),
        .o_err      (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference flag register and expected outputs of the last modelled op.
    bit          m_c, m_z, m_n, m_v;
    logic [15:0] e_res, e_hi;
    logic        e_err;
    int          e_lat;

    // Values observed by the last run_op, for spec-vector checks.
    logic [15:0] o_res, o_hi;
    logic [3:0]  o_flg;
    logic        o_er;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_flags();
        return {m_c, m_z, m_n, m_v};
    endfunction

    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int     ua, ub, sa, sb, full, sres, n, cin;
        longint prod;
        bit     c, v, legal, is_mul;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(b[3:0]);
        c = m_c; v = 1'b0; legal = 1'b1; is_mul = 1'b0;
        full = 0; sres = 0; cin = int'(m_c);
        e_hi = 16'h0; e_lat = 1;
        case (op)
            4'h0: begin full = ua + ub; c = full > 65535; sres = sa + sb; end
            4'h1: begin full = ua + ub + cin; c = full > 65535; sres = sa + sb + cin; end
            4'h2: begin full = ua - ub; c = ua >= ub; sres = sa - sb; end
            4'h3: begin
                full = ua - ub - (1 - cin);
                c    = ua >= ub + (1 - cin);
                sres = sa - sb - (1 - cin);
            end
            4'h4: full = ua & ub;
            4'h5: full = ua | ub;
            4'h6: full = ua ^ ub;
            4'h7: full = ~ua;
            4'h8: begin full = ua << n; if (n != 0) c = ((ua >> (16 - n)) & 1) != 0; end
            4'h9: begin full = ua >> n; if (n != 0) c = ((ua >> (n - 1)) & 1) != 0; end
            4'hA: begin full = sa >>> n; if (n != 0) c = ((ua >> (n - 1)) & 1) != 0; end
`ifdef ALU_MUL_EN
            4'hB: begin
                is_mul = 1'b1;
                prod   = longint'(ua) * longint'(ub);
                e_res  = prod[15:0];
                e_hi   = prod[31:16];
                c      = e_hi != 16'h0;
                v      = c;
                e_lat  = 17;
            end
`endif
            default: legal = 1'b0;
        endcase
        if (op <= 4'h3) v = (sres > 32767) || (sres < -32768);
        if (!is_mul) e_res = full[15:0];
        if (legal) begin
            e_err = 1'b0;
            m_c = c; m_v = v; m_z = (e_res == 16'h0); m_n = e_res[15];
        end else begin
            e_err = 1'b1; e_res = 16'h0; e_hi = 16'h0;
        end
    endtask

    // Issue one op, wait for its result, compare against the model, then drain it.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input string tag);
        int n;
        int lat;
        model(op, a, b);
        @(negedge clk);
        opcode = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Operands must have been captured; scramble them.
        in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); opcode = 4'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        o_res = result; o_hi = result_hi; o_flg = flags; o_er = err;
        chk({tag, ":lat"}, 32'(lat), 32'(e_lat));
        chk({tag, ":res"}, 32'(result), 32'(e_res));
        chk({tag, ":hi"}, 32'(result_hi), 32'(e_hi));
        chk({tag, ":flags"}, 32'(flags), 32'(m_flags()));
        chk({tag, ":err"}, 32'(err), 32'(e_err));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] h_res;
        logic [3:0]  h_flg;
        logic [15:0] ra, rb;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst:out_valid", 32'(out_valid), 32'd0);
        chk("rst:in_ready", 32'(in_ready), 32'd1);
        chk("rst:res", 32'(result), 32'd0);
        chk("rst:hi", 32'(result_hi), 32'd0);
        chk("rst:flags", 32'(flags), 32'd0);
        chk("rst:err", 32'(err), 32'd0);
        rst_n = 1'b1;
        m_c = 0; m_z = 0; m_n = 0; m_v = 0;

        // Spec vectors
        run_op(4'h0, 16'hFFFF, 16'h0001, "add_wrap");
        chk("add_wrap:spec_res", 32'(o_res), 32'h0000);
        chk("add_wrap:spec_flags", 32'(o_flg), 32'b1100);
        run_op(4'h1, 16'h0000, 16'h0000, "adc_chain");
        chk("adc_chain:spec_res", 32'(o_res), 32'h0001);
        chk("adc_chain:spec_c", 32'(o_flg[3]), 32'd0);
        run_op(4'h2, 16'h8000, 16'h0001, "sub_ovf");
        chk("sub_ovf:spec", {16'(o_res), 12'h0, o_flg}, {16'h7FFF, 12'h0, 4'b1001});
        run_op(4'h2, 16'h0000, 16'h0001, "sub_borrow");
        chk("sub_borrow:spec", {16'(o_res), 12'h0, o_flg}, {16'hFFFF, 12'h0, 4'b0010});
        run_op(4'h9, 16'h0003, 16'h0001, "shr1");
        chk("shr1:spec", {16'(o_res), 15'h0, o_flg[3]}, {16'h0001, 15'h0, 1'b1});
        run_op(4'h8, 16'hA5A5, 16'hFFF0, "shl0");
        chk("shl0:spec", {16'(o_res), 15'h0, o_flg[3]}, {16'hA5A5, 15'h0, 1'b1});
        run_op(4'hA, 16'h8000, 16'h000F, "sar15");
        chk("sar15:spec", {16'(o_res), 15'h0, o_flg[3]}, {16'hFFFF, 15'h0, 1'b0});
        h_flg = o_flg;
        run_op(4'hF, 16'h1234, 16'h5678, "illegal_f");
        chk("illegal_f:spec", {16'(o_res), 11'h0, o_er, o_flg}, {16'h0, 11'h0, 1'b1, h_flg});
        run_op(4'hB, 16'h1234, 16'h0100, "mul_spec");
`ifdef ALU_MUL_EN
        chk("mul_spec:spec", {o_hi, o_res}, 32'h0012_3400);
        chk("mul_spec:cv", 32'({o_flg[3], o_flg[0]}), 32'b11);
`else
        chk("opb_illegal:err", 32'(o_er), 32'd1);
`endif

        // Backpressure hold, then back-to-back accept
        model(4'h0, 16'h7FFF, 16'h0001);
        @(negedge clk);
        opcode = 4'h0; in_a = 16'h7FFF; in_b = 16'h0001; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold:valid", 32'(out_valid), 32'd1);
        chk("hold:res", 32'(result), 32'(e_res));
        chk("hold:flags", 32'(flags), 32'(m_flags()));
        h_res = e_res;
        h_flg = m_flags();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold:stable_res", 32'(result), 32'(h_res));
            chk("hold:stable_flags", 32'(flags), 32'(h_flg));
            chk("hold:stable_valid", 32'(out_valid), 32'd1);
            chk("hold:in_ready_low", 32'(in_ready), 32'd0);
        end
        model(4'h6, 16'h0FF0, 16'h00FF);
        opcode = 4'h6; in_a = 16'h0FF0; in_b = 16'h00FF; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b:in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b:valid", 32'(out_valid), 32'd1);
        chk("b2b:res", 32'(result), 32'(e_res));
        chk("b2b:flags", 32'(flags), 32'(m_flags()));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset while a result is held
        run_op(4'h2, 16'h0000, 16'h0005, "pre_rst");
        @(negedge clk);
        opcode = 4'h0; in_a = 16'hFFFF; in_b = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_held:valid", 32'(out_valid), 32'd0);
        chk("rst_held:flags", 32'(flags), 32'd0);
        chk("rst_held:in_ready", 32'(in_ready), 32'd1);
        m_c = 0; m_z = 0; m_n = 0; m_v = 0;

`ifdef ALU_MUL_EN
        // Reset in the middle of a multiply
        @(negedge clk);
        opcode = 4'hB; in_a = 16'h1234; in_b = 16'h0100; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mul:valid", 32'(out_valid), 32'd0);
        chk("rst_mul:flags", 32'(flags), 32'd0);
        chk("rst_mul:in_ready", 32'(in_ready), 32'd1);
        chk("rst_mul:res", 32'(result), 32'd0);
`endif
        run_op(4'h1, 16'h0001, 16'h0002, "adc_after_rst");

        // Randomized ops with occasional corner operands
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 5 == 0) ra = 16'h8000;
            if (i % 7 == 0) rb = 16'hFFFF;
            run_op(4'($urandom_range(0, 15)), ra, rb, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
